// File: rtl/tactile_frame_arbiter.sv
// Double-buffered tactile frame store: captures packed cells, publishes whole frames atomically and
// shares the single RAM read port between CPU word reads and stream bursts. Macro TACTILE_FRAME_TAG_EN
// prefixes every burst with the published frame count.
module tactile_frame_arbiter #(
  parameter int CELLS     = 256,
  parameter int DATA_BITS = 32,
  parameter int IDX_BITS  = $clog2(CELLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_strobe,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 cpu_valid,
  input  logic [IDX_BITS-1:0]  cpu_addr,
  input  logic                 cpu_lock,
  output logic                 cpu_ready,
  output logic [DATA_BITS-1:0] cpu_rdata,
  input  logic                 st_req,
  input  logic                 st_ready,
  output logic                 st_valid,
  output logic [DATA_BITS-1:0] st_data,
  output logic                 st_last,
  output logic                 st_busy,
  output logic [31:0]          frame_count,
  output logic [31:0]          drop_count
);

`ifdef TACTILE_FRAME_TAG_EN
  localparam logic TAG_EN = 1'b1;
`else
  localparam logic TAG_EN = 1'b0;
`endif

  localparam int                DEPTH    = 2 ** (IDX_BITS + 1);
  localparam logic [IDX_BITS:0] CELLS_W  = (IDX_BITS + 1)'(CELLS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(CELLS - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BURST = 1'b1} state_t;

  logic [DATA_BITS-1:0] mem_r [DEPTH];
  logic [DATA_BITS-1:0] rd_data_r;
  logic                 wb_r;
  logic                 has_frame_r;
  logic [31:0]          frame_count_r;
  logic [31:0]          drop_count_r;
  state_t               state_r;
  state_t               state_n;
  logic                 st_busy_r;
  logic [IDX_BITS:0]    iss_idx_r;
  logic                 hdr_pend_r;
  logic                 prefer_cpu_r;
  logic                 s1_cpu_r;
  logic                 s1_zero_r;
  logic                 s1_st_r;
  logic                 s1_hdr_r;
  logic                 s1_last_r;
  logic                 cpu_ready_r;
  logic [DATA_BITS-1:0] cpu_rdata_r;
  logic                 out_valid_r;
  logic                 out_last_r;
  logic [DATA_BITS-1:0] out_data_r;
  logic                 skid_valid_r;
  logic                 skid_last_r;
  logic [DATA_BITS-1:0] skid_data_r;

  logic                 wr_ok_s;
  logic                 frame_end_s;
  logic                 swap_s;
  logic                 pop_s;
  logic [1:0]           occ_s;
  logic                 credit_s;
  logic                 hdr_issue_s;
  logic                 st_rd_req_s;
  logic                 cpu_req_s;
  logic                 cpu_gnt_s;
  logic                 st_gnt_s;
  logic                 rd_en_s;
  logic [IDX_BITS:0]    rd_addr_s;
  logic [DATA_BITS-1:0] hdr_word_s;
  logic [DATA_BITS-1:0] push_data_s;

  // Write qualification, frame-end detection and publish decision.
  always_comb begin
    wr_ok_s     = wr_strobe && ({1'b0, wr_index} < CELLS_W);
    frame_end_s = wr_strobe && (wr_index == LAST_IDX);
    swap_s      = frame_end_s && !st_busy_r && !cpu_lock;
  end

  // Skid credit: words stored plus words in the RAM stage must leave room for one more issue.
  always_comb begin
    pop_s       = out_valid_r && st_ready;
    occ_s       = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, s1_st_r} - {1'b0, pop_s};
    credit_s    = (occ_s <= 2'd1);
    hdr_word_s  = DATA_BITS'(frame_count_r);
    push_data_s = s1_hdr_r ? hdr_word_s : rd_data_r;
  end

  // Stream FSM next state and stream read requests.
  always_comb begin
    state_n     = state_r;
    hdr_issue_s = 1'b0;
    st_rd_req_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (st_req && has_frame_r) begin
          state_n = S_BURST;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_BURST: begin
        if (credit_s && hdr_pend_r) begin
          hdr_issue_s = 1'b1;
        end else begin
          hdr_issue_s = 1'b0;
        end
        if (credit_s && !hdr_pend_r && (iss_idx_r < CELLS_W)) begin
          st_rd_req_s = 1'b1;
        end else begin
          st_rd_req_s = 1'b0;
        end
        if (pop_s && out_last_r) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_BURST;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Read-port arbitration; on contention the previous winner yields.
  always_comb begin
    cpu_req_s = cpu_valid && !s1_cpu_r && !cpu_ready_r;
    if (cpu_req_s && st_rd_req_s) begin
      cpu_gnt_s = prefer_cpu_r;
      st_gnt_s  = !prefer_cpu_r;
    end else begin
      cpu_gnt_s = cpu_req_s;
      st_gnt_s  = st_rd_req_s;
    end
    rd_en_s = cpu_gnt_s || st_gnt_s;
    if (cpu_gnt_s) begin
      rd_addr_s = {~wb_r, cpu_addr};
    end else begin
      rd_addr_s = {~wb_r, iss_idx_r[IDX_BITS-1:0]};
    end
  end

  // Frame RAM: write bank wb, registered read of the published bank.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[{wb_r, wr_index}] <= wr_data;
    end
    if (rd_en_s) begin
      rd_data_r <= mem_r[rd_addr_s];
    end
  end

  // Bank ownership and frame statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_r          <= 1'b0;
      has_frame_r   <= 1'b0;
      frame_count_r <= 32'd0;
      drop_count_r  <= 32'd0;
    end else if (swap_s) begin
      wb_r          <= ~wb_r;
      has_frame_r   <= 1'b1;
      frame_count_r <= frame_count_r + 32'd1;
    end else if (frame_end_s) begin
      drop_count_r  <= drop_count_r + 32'd1;
    end
  end

  // Stream FSM state, burst issue counter and arbiter history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= S_IDLE;
      st_busy_r    <= 1'b0;
      iss_idx_r    <= '0;
      hdr_pend_r   <= 1'b0;
      prefer_cpu_r <= 1'b1;
    end else begin
      state_r   <= state_n;
      st_busy_r <= (state_n == S_BURST);
      if (state_r == S_IDLE) begin
        iss_idx_r  <= '0;
        hdr_pend_r <= TAG_EN;
      end else begin
        if (st_gnt_s) begin
          iss_idx_r <= iss_idx_r + (IDX_BITS + 1)'(1);
        end
        if (hdr_issue_s) begin
          hdr_pend_r <= 1'b0;
        end
      end
      if (cpu_gnt_s) begin
        prefer_cpu_r <= 1'b0;
      end else if (st_gnt_s) begin
        prefer_cpu_r <= 1'b1;
      end
    end
  end

  // RAM-stage tags and registered CPU response.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_cpu_r    <= 1'b0;
      s1_zero_r   <= 1'b0;
      s1_st_r     <= 1'b0;
      s1_hdr_r    <= 1'b0;
      s1_last_r   <= 1'b0;
      cpu_ready_r <= 1'b0;
      cpu_rdata_r <= '0;
    end else begin
      s1_cpu_r    <= cpu_gnt_s;
      s1_zero_r   <= !has_frame_r;
      s1_st_r     <= st_gnt_s || hdr_issue_s;
      s1_hdr_r    <= hdr_issue_s;
      s1_last_r   <= st_gnt_s && (iss_idx_r[IDX_BITS-1:0] == LAST_IDX);
      cpu_ready_r <= s1_cpu_r;
      if (s1_cpu_r) begin
        cpu_rdata_r <= s1_zero_r ? '0 : rd_data_r;
      end
    end
  end

  // Two-entry skid: output register backed by one spill register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_data_r   <= '0;
      skid_valid_r <= 1'b0;
      skid_last_r  <= 1'b0;
      skid_data_r  <= '0;
    end else if (!out_valid_r || st_ready) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_last_r   <= skid_last_r;
        out_data_r   <= skid_data_r;
        skid_valid_r <= s1_st_r;
        skid_last_r  <= s1_last_r;
        skid_data_r  <= push_data_s;
      end else begin
        out_valid_r  <= s1_st_r;
        out_last_r   <= s1_last_r;
        out_data_r   <= push_data_s;
      end
    end else if (s1_st_r) begin
      skid_valid_r <= 1'b1;
      skid_last_r  <= s1_last_r;
      skid_data_r  <= push_data_s;
    end
  end

  assign cpu_ready   = cpu_ready_r;
  assign cpu_rdata   = cpu_rdata_r;
  assign st_valid    = out_valid_r;
  assign st_data     = out_data_r;
  assign st_last     = out_valid_r && out_last_r;
  assign st_busy     = st_busy_r;
  assign frame_count = frame_count_r;
  assign drop_count  = drop_count_r;

endmodule

// File: tb/tb_tactile_frame_arbiter.sv
// Directed bench for tactile_frame_arbiter: scoreboard queues for stream words and CPU reads,
// immediate assertions at every comparison.
module tb_tactile_frame_arbiter;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } sw_t;

  logic        clk;
  logic        rst;
  logic        wr_strobe;
  logic [7:0]  wr_index;
  logic [31:0] wr_data;
  logic        cpu_valid;
  logic [7:0]  cpu_addr;
  logic        cpu_lock;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        st_req;
  logic        st_ready;
  logic        st_valid;
  logic [31:0] st_data;
  logic        st_last;
  logic        st_busy;
  logic [31:0] frame_count;
  logic [31:0] drop_count;

  int          compared;
  int          mismatched;
  int          st_words;
  int          busy_cyc;
  bit          rand_mode;
  sw_t         st_q[$];
  logic [31:0] cpu_q[$];

  tactile_frame_arbiter dut (
    .clk(clk), .rst(rst), .wr_strobe(wr_strobe), .wr_index(wr_index), .wr_data(wr_data),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_lock(cpu_lock), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .st_req(st_req), .st_ready(st_ready), .st_valid(st_valid),
    .st_data(st_data), .st_last(st_last), .st_busy(st_busy), .frame_count(frame_count),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) st_ready = 1'($urandom_range(0, 1));
    else st_ready = 1'b1;
  endtask

  task automatic write_frame(input int off);
    for (int i = 0; i < 256; i++) begin
      wr_strobe = 1'b1;
      wr_index  = 8'(i);
      wr_data   = 32'(i + off);
      tick();
    end
    wr_strobe = 1'b0;
  endtask

  task automatic push_frame(input int off, input int hdr);
`ifdef TACTILE_FRAME_TAG_EN
    st_q.push_back({1'b0, 32'(hdr)});
`endif
    for (int i = 0; i < 256; i++) st_q.push_back({(i == 255), 32'(i + off)});
  endtask

  task automatic cpu_read(input logic [7:0] a, input logic [31:0] exp, input int lat, input bit exact);
    int  k;
    bit  seen;
    cpu_q.push_back(exp);
    cpu_addr  = a;
    cpu_valid = 1'b1;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 20) begin
      tick();
      k++;
      if (cpu_ready) seen = 1'b1;
    end
    cpu_valid = 1'b0;
    chk("cpu_ready_seen", 64'(seen), 64'd1);
    if (!seen) void'(cpu_q.pop_back());
    else if (exact) chk("cpu_latency", 64'(k), 64'(lat));
    else chk("cpu_latency_bound", 64'(k <= lat), 64'd1);
  endtask

  task automatic wait_burst(input int limit);
    int g;
    g = 0;
    while ((st_busy || st_q.size() != 0) && g < limit) begin
      tick();
      g++;
    end
    chk("burst_done", {62'd0, st_busy, st_q.size() == 0}, 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_ready"}, 64'(cpu_ready), 64'd0);
    chk({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
    chk({tag, "_st_valid"}, 64'(st_valid), 64'd0);
    chk({tag, "_st_last"}, 64'(st_last), 64'd0);
    chk({tag, "_st_busy"}, 64'(st_busy), 64'd0);
    chk({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({tag, "_drop_count"}, 64'(drop_count), 64'd0);
  endtask

  // Output monitor: pops the scoreboards as the DUT delivers words.
  initial begin
    sw_t         e;
    logic [31:0] c;
    forever begin
      @(negedge clk);
      if (st_busy) busy_cyc++;
      if (st_valid && st_ready) begin
        st_words++;
        chk("st_word_expected", 64'(st_q.size() != 0), 64'd1);
        if (st_q.size() != 0) begin
          e = st_q.pop_front();
          chk("st_word", {31'd0, st_last, st_data}, {31'd0, e.last, e.data});
        end
      end
      if (cpu_ready) begin
        chk("cpu_resp_expected", 64'(cpu_q.size() != 0), 64'd1);
        if (cpu_q.size() != 0) begin
          c = cpu_q.pop_front();
          chk("cpu_rdata", 64'(cpu_rdata), 64'(c));
        end
      end
    end
  end

  initial begin
    bit          saw;
    int          g;
    int          grants;
    int          base;
    int          lo;
    logic [7:0]  a;
    compared = 0; mismatched = 0; st_words = 0; busy_cyc = 0; rand_mode = 1'b0;
    rst = 1'b1; wr_strobe = 1'b0; wr_index = 8'd0; wr_data = 32'd0;
    cpu_valid = 1'b0; cpu_addr = 8'd0; cpu_lock = 1'b0; st_req = 1'b0; st_ready = 1'b1;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Nothing published yet: zero data, stream request stays unanswered.
    cpu_read(8'd5, 32'd0, 2, 1'b1);
    st_req = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      tick();
      if (st_valid || st_busy) saw = 1'b1;
    end
    st_req = 1'b0;
    chk("no_stream_before_frame", 64'(saw), 64'd0);

    // Frame A published.
    write_frame(0);
    chk("fc_after_A", 64'(frame_count), 64'd1);
    chk("dc_after_A", 64'(drop_count), 64'd0);
    cpu_read(8'd7, 32'd7, 2, 1'b1);

    // Burst of A under random backpressure while frame B lands and is dropped.
    push_frame(0, 1);
    rand_mode = 1'b1;
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
    chk("busy_entry", 64'(st_busy), 64'd1);
    chk("valid_n1", 64'(st_valid), 64'd0);
    tick();
    chk("valid_n2", 64'(st_valid), 64'd0);
    tick();
    chk("valid_n3", 64'(st_valid), 64'd1);
    write_frame(1000);
    wait_burst(4000);
    rand_mode = 1'b0;
    chk("dc_after_B", 64'(drop_count), 64'd1);
    chk("fc_after_B", 64'(frame_count), 64'd1);

    // Lock held across two frame ends: both dropped, A still visible.
    cpu_lock = 1'b1;
    write_frame(2000);
    write_frame(3000);
    chk("dc_locked", 64'(drop_count), 64'd3);
    chk("fc_locked", 64'(frame_count), 64'd1);
    cpu_read(8'd9, 32'd9, 2, 1'b1);
    cpu_lock = 1'b0;
    write_frame(5000);
    chk("fc_after_C", 64'(frame_count), 64'd2);
    cpu_read(8'd9, 32'd5009, 2, 1'b1);

    // Burst of C with interleaved CPU reads.
    push_frame(5000, 2);
    busy_cyc = 0;
    grants = 0;
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
    g = 0;
    while (st_busy && g < 200) begin
      a = 8'(g * 37 + 11);
      cpu_read(a, 32'd5000 + 32'(a), 5, 1'b0);
      grants++;
      tick();
      g++;
    end
    wait_burst(100);
`ifdef TACTILE_FRAME_TAG_EN
    lo = 259;
`else
    lo = 258;
`endif
    chk("burst_len_bound", 64'((busy_cyc >= lo) && (busy_cyc <= lo + grants)), 64'd1);

    // Reset in the middle of a burst with a CPU read in flight.
    push_frame(5000, 2);
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
    base = st_words;
    g = 0;
    while (st_words < base + 100 && g < 1000) begin
      tick();
      g++;
    end
    chk("reached_word_100", 64'(st_words >= base + 100), 64'd1);
    cpu_addr = 8'd3;
    cpu_valid = 1'b1;
    tick();
    rst = 1'b1;
    cpu_valid = 1'b0;
    tick();
    st_q.delete();
    check_reset("mid_rst");
    rst = 1'b0;
    saw = 1'b0;
    repeat (3) begin
      tick();
      if (cpu_ready || st_valid) saw = 1'b1;
    end
    chk("no_pending_after_rst", 64'(saw), 64'd0);
    cpu_read(8'd3, 32'd0, 2, 1'b1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
